// File: rtl/phoenix_pwm_generator.sv
`default_nettype none
// ============================================================================
// Module      : phoenix_pwm_generator
// Description : Double-buffered PWM generator. Period and high-time requests
//               are shadowed and applied only at a period boundary.
//               Optional macro PHOENIX_PWM_PERIOD_STROBE_EN adds a registered
//               period_start strobe; otherwise period_start is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module phoenix_pwm_generator #(
  parameter int PWM_COUNTER_BITS = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [PWM_COUNTER_BITS-1:0] pwm_cycle,
  input  logic [PWM_COUNTER_BITS-1:0] pwm_duty,
  output logic                        pwm_out,
  output logic                        period_start
);

  localparam int W = PWM_COUNTER_BITS;

  logic [W-1:0] counter_q, counter_d;
  logic [W-1:0] cycle_q, cycle_d;
  logic [W-1:0] duty_q, duty_d;
  logic         pwm_q, pwm_d;
  logic [W:0]   w_count_inc;
  logic         w_term;

  // One extra bit so counter+1 never wraps when cycle is at its maximum.
  assign w_count_inc = {1'b0, counter_q} + {{W{1'b0}}, 1'b1};
  assign w_term      = (cycle_q == '0) || (w_count_inc >= {1'b0, cycle_q});

  always_comb begin
    counter_d = w_term ? '0 : w_count_inc[W-1:0];
    cycle_d   = w_term ? pwm_cycle : cycle_q;
    duty_d    = w_term ? pwm_duty  : duty_q;
    pwm_d     = (cycle_q != '0) && (counter_q < duty_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      counter_q <= '0;
      cycle_q   <= '0;
      duty_q    <= '0;
      pwm_q     <= 1'b0;
    end else begin
      counter_q <= counter_d;
      cycle_q   <= cycle_d;
      duty_q    <= duty_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

`ifdef PHOENIX_PWM_PERIOD_STROBE_EN
  logic period_start_q, period_start_d;

  // High during the clk in which counter==0 of a freshly loaded nonzero period.
  assign period_start_d = w_term && (pwm_cycle != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      period_start_q <= 1'b0;
    end else begin
      period_start_q <= period_start_d;
    end
  end

  assign period_start = period_start_q;
`else
  assign period_start = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_phoenix_pwm_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_phoenix_pwm_generator
// Description : Self-checking bench for phoenix_pwm_generator (vector table,
//               directed sequences and randomized traffic against a model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phoenix_pwm_generator;

  localparam int W = 32;
`ifdef PHOENIX_PWM_PERIOD_STROBE_EN
  localparam bit STROBE = 1'b1;
`else
  localparam bit STROBE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] pwm_cycle = '0;
  logic [W-1:0] pwm_duty = '0;
  logic         pwm_out;
  logic         period_start;

  int n_cmp = 0;
  int n_err = 0;

  // Model: remaining high and low clks of the period currently being emitted.
  longint m_hi, m_lo;
  bit     m_out, m_ps;

  phoenix_pwm_generator #(.PWM_COUNTER_BITS(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .pwm_cycle    (pwm_cycle),
    .pwm_duty     (pwm_duty),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           rst;
    logic [W-1:0] cyc;
    logic [W-1:0] duty;
    bit           exp_out;
    bit           exp_ps;   // value when the strobe feature is built in
  } vec_t;

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input logic [W-1:0] c, input logic [W-1:0] d);
    longint lc, ld;
    lc = longint'(c);
    ld = longint'(d);
    if (!rst) begin
      m_out = 1'b0; m_ps = 1'b0; m_hi = 0; m_lo = 1;
    end else begin
      m_out = (m_hi > 0);
      if (m_hi > 0) m_hi--; else m_lo--;
      m_ps = 1'b0;
      if (m_hi == 0 && m_lo == 0) begin
        if (lc == 0) begin
          m_hi = 0; m_lo = 1;
        end else begin
          m_hi = (ld < lc) ? ld : lc;
          m_lo = lc - m_hi;
          m_ps = 1'b1;
        end
      end
    end
  endtask

  // Drive one clk worth of inputs, advance the model, sample 1 time unit after the edge.
  task automatic step(input bit rst, input logic [W-1:0] c, input logic [W-1:0] d);
    @(negedge clk);
    reset = rst; pwm_cycle = c; pwm_duty = d;
    @(posedge clk);
    model_step(rst, c, d);
    #1;
  endtask

  task automatic check_model(input string name);
    check({name, "_out"}, pwm_out, m_out);
    check({name, "_ps"}, period_start, STROBE ? m_ps : 1'b0);
  endtask

  vec_t vecs[17];

  initial begin
    m_hi = 0; m_lo = 1; m_out = 0; m_ps = 0;

    vecs[0]  = '{0, 4, 2, 0, 0};
    vecs[1]  = '{1, 4, 2, 0, 1};
    vecs[2]  = '{1, 4, 2, 1, 0};
    vecs[3]  = '{1, 4, 2, 1, 0};
    vecs[4]  = '{1, 4, 2, 0, 0};
    vecs[5]  = '{1, 3, 5, 0, 1};
    vecs[6]  = '{1, 0, 0, 1, 0};
    vecs[7]  = '{1, 0, 0, 1, 0};
    vecs[8]  = '{1, 0, 0, 1, 0};
    vecs[9]  = '{1, 1, 1, 0, 1};
    vecs[10] = '{1, 1, 0, 1, 1};
    vecs[11] = '{1, 2, 1, 0, 1};
    vecs[12] = '{1, 2, 1, 1, 0};
    vecs[13] = '{1, 2, 1, 0, 1};
    vecs[14] = '{0, 2, 1, 0, 0};
    vecs[15] = '{1, 2, 1, 0, 1};
    vecs[16] = '{1, 2, 1, 1, 0};

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].rst, vecs[i].cyc, vecs[i].duty);
      check($sformatf("vec%0d_out", i), pwm_out, vecs[i].exp_out);
      check($sformatf("vec%0d_ps", i), period_start, STROBE ? vecs[i].exp_ps : 1'b0);
    end

    // 10/3 period, request 20/5 once counter reaches 4: old period completes first.
    step(0, 10, 3);
    step(1, 10, 3);
    for (int n = 1; n <= 31; n++) begin
      step(1, (n <= 4) ? 10 : 20, (n <= 4) ? 3 : 5);
      check($sformatf("midchg_e%0d", n), pwm_out,
            (n >= 1 && n <= 3) || (n >= 11 && n <= 15) || (n == 31));
    end

    // Full-on: duty beyond cycle never drops low across boundaries.
    step(0, 10, 12);
    step(1, 10, 12);
    step(1, 10, 12);
    for (int n = 0; n < 50; n++) begin
      step(1, 10, 12);
      check("duty_ge_cycle", pwm_out, 1'b1);
    end

    // Reset pulse during high phase restarts the waveform.
    step(0, 10, 5);
    step(1, 10, 5);
    step(1, 10, 5);
    step(1, 10, 5);
    step(0, 10, 5);
    check("rst_mid_out", pwm_out, 1'b0);
    step(1, 10, 5);
    check("rst_rel_e0", pwm_out, 1'b0);
    for (int n = 0; n < 5; n++) begin
      step(1, 10, 5);
      check("rst_rel_high", pwm_out, 1'b1);
    end
    step(1, 10, 5);
    check("rst_rel_low", pwm_out, 1'b0);

    // Idle cycle=0, then a 4/2 request is picked up immediately.
    for (int n = 0; n < 20; n++) begin
      step(1, 0, 5);
      if (n >= 10) begin
        check("idle_out", pwm_out, 1'b0);
        check("idle_ps", period_start, 1'b0);
      end
    end
    step(1, 4, 2);
    check("idle_exit_ps", period_start, STROBE);
    step(1, 4, 2); check("idle_exit_1", pwm_out, 1'b1);
    step(1, 4, 2); check("idle_exit_2", pwm_out, 1'b1);
    step(1, 4, 2); check("idle_exit_3", pwm_out, 1'b0);
    step(1, 4, 2); check("idle_exit_4", pwm_out, 1'b0);
    step(1, 4, 2); check("idle_exit_5", pwm_out, 1'b1);

    // cycle=1, duty=1: constant high, strobe every clk.
    for (int n = 0; n < 10; n++) begin
      step(1, 1, 1);
      if (n >= 5) begin
        check("c1_out", pwm_out, 1'b1);
        check("c1_ps", period_start, STROBE);
      end
    end
    for (int n = 0; n < 15; n++) begin
      step(1, 5, 2);
      check_model("c5");
    end

    // Maximum period: counter compare must not wrap.
    step(0, '1, '1 - 32'd4);
    for (int n = 0; n < 40; n++) begin
      step(1, '1, '1 - 32'd4);
      check_model("maxcyc");
    end

    // Randomized traffic against the model.
    begin
      logic [W-1:0] rc, rd;
      bit rr;
      rc = 6; rd = 2;
      for (int n = 0; n < 600; n++) begin
        rr = ($urandom_range(0, 60) != 0);
        if ($urandom_range(0, 7) == 0) begin
          rc = W'($urandom_range(0, 12));
          rd = ($urandom_range(0, 9) == 0) ? '1 : W'($urandom_range(0, 14));
        end
        step(rr, rc, rd);
        check_model("rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
